// File: rtl/snake_head_stepper_pkg.sv
// Shared definitions for the snake head stepper:
// direction codes, FSM state codes and the opposite-direction helper.
package snake_head_stepper_pkg;

  typedef logic [1:0] dir_t;

  localparam dir_t TOP_DIR   = 2'b00;
  localparam dir_t RIGHT_DIR = 2'b01;
  localparam dir_t DOWN_DIR  = 2'b10;
  localparam dir_t LEFT_DIR  = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;

  // Opposite headings differ only in the upper bit.
  function automatic dir_t opposite(input dir_t d);
    return d ^ 2'b10;
  endfunction

endpackage

// File: rtl/snake_head_stepper_tick_divider.sv
// tick_divider: counts enabled cycles, pulses tick on the wrap.
// Ports: clk, rst_n, en (count), clr (sync clear), tick (1-cycle pulse).
module tick_divider #(
  parameter int TICK_DIV = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // clr wins over en so a clearing cycle never emits a tick.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head stepper: game-speed timer, heading with reversal reject,
// toroidal head coordinates. Inputs: direction, run, restart.
// Outputs (all registered): head_x, head_y, heading, step, state.
module snake_head_stepper
  import snake_head_stepper_pkg::*;
#(
  parameter int GRID_W   = 40,
  parameter int GRID_H   = 30,
  parameter int TICK_DIV = 2_500_000,
  parameter int START_X  = 20,
  parameter int START_Y  = 15,
  localparam int XW = $clog2(GRID_W),
  localparam int YW = $clog2(GRID_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    direction,
  input  logic          run,
  input  logic          restart,
  output logic [XW-1:0] head_x,
  output logic [YW-1:0] head_y,
  output logic [1:0]    heading,
  output logic          step,
  output logic [1:0]    state
);

  localparam logic [XW-1:0] X0   = XW'(START_X);
  localparam logic [YW-1:0] Y0   = YW'(START_Y);
  localparam logic [XW-1:0] XMAX = XW'(GRID_W - 1);
  localparam logic [YW-1:0] YMAX = YW'(GRID_H - 1);

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  dir_t          head_q, head_d;
  logic          step_q, step_d;
  logic          tick;
  logic          cnt_en;
  logic          cnt_clr;

  assign cnt_en  = (state_q == ST_RUN);
  assign cnt_clr = restart || (state_q == ST_IDLE);

  tick_divider #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (run)  state_d = ST_RUN;
      ST_RUN:   if (!run) state_d = ST_PAUSE;
      ST_PAUSE: if (run)  state_d = ST_RUN;
      default:            state_d = ST_IDLE;
    endcase
    if (restart) state_d = ST_IDLE;
  end

  // The move uses the heading latched in this same step.
  always_comb begin
    head_d = head_q;
    x_d    = x_q;
    y_d    = y_q;
    step_d = 1'b0;
    if (restart) begin
      head_d = TOP_DIR;
      x_d    = X0;
      y_d    = Y0;
    end else if (tick) begin
      step_d = 1'b1;
      if (direction != opposite(head_q)) head_d = direction;
      unique case (head_d)
        TOP_DIR:   y_d = (y_q == '0)   ? YMAX : y_q - 1'b1;
        DOWN_DIR:  y_d = (y_q == YMAX) ? '0   : y_q + 1'b1;
        LEFT_DIR:  x_d = (x_q == '0)   ? XMAX : x_q - 1'b1;
        RIGHT_DIR: x_d = (x_q == XMAX) ? '0   : x_q + 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= X0;
      y_q     <= Y0;
      head_q  <= TOP_DIR;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      head_q  <= head_d;
      step_q  <= step_d;
    end
  end

  assign head_x  = x_q;
  assign head_y  = y_q;
  assign heading = head_q;
  assign step    = step_q;
  assign state   = state_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper with a
// cycle-level behavioural model and randomized stimulus.
module tb_snake_head_stepper;

  localparam int GW = 40;
  localparam int GH = 30;
  localparam int TD = 4;
  localparam int SX = 20;
  localparam int SY = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] direction = 2'd0;
  logic [5:0] head_x;
  logic [4:0] head_y;
  logic [1:0] heading;
  logic       step;
  logic [1:0] state;

  int checks = 0;
  int failures = 0;

  // model: 0 idle, 1 run, 2 pause; cnt = RUN cycles since last step
  int m_state, m_cnt, mx, my, mhead, mstep;

  always #5 clk = ~clk;

  snake_head_stepper #(
    .GRID_W   (GW),
    .GRID_H   (GH),
    .TICK_DIV (TD),
    .START_X  (SX),
    .START_Y  (SY)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .direction (direction),
    .run       (run),
    .restart   (restart),
    .head_x    (head_x),
    .head_y    (head_y),
    .heading   (heading),
    .step      (step),
    .state     (state)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = 0;
    mx      = SX;
    my      = SY;
    mhead   = 0;
    mstep   = 0;
  endtask

  task automatic model_clk();
    bit fire;
    fire = 0;
    if (restart) begin
      model_reset();
      return;
    end
    if (m_state == 1) begin
      m_cnt++;
      if (m_cnt == TD) begin
        m_cnt = 0;
        fire  = 1;
      end
    end else if (m_state == 0) begin
      m_cnt = 0;
    end
    mstep = fire;
    if (fire) begin
      if (int'(direction) != (mhead + 2) % 4) mhead = direction;
      case (mhead)
        0: my = (my + GH - 1) % GH;
        1: mx = (mx + 1) % GW;
        2: my = (my + 1) % GH;
        default: mx = (mx + GW - 1) % GW;
      endcase
    end
    case (m_state)
      0: if (run) m_state = 1;
      1: if (!run) m_state = 2;
      default: if (run) m_state = 1;
    endcase
  endtask

  task automatic check_all();
    check_eq("step", step, mstep);
    check_eq("head_x", head_x, mx);
    check_eq("head_y", head_y, my);
    check_eq("heading", heading, mhead);
    check_eq("state", state, m_state);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic wait_step(input string tag, output int n);
    n = 0;
    do begin
      cyc();
      n++;
    end while (!step && n < 64);
    if (!step) check_eq({tag, "_timeout"}, step, 1);
  endtask

  task automatic wait_cnt(input int c);
    int n;
    n = 0;
    while (!(m_state == 1 && m_cnt == c) && n < 64) begin
      cyc();
      n++;
    end
    if (n >= 64) check_eq("wait_cnt_timeout", state, 9);
  endtask

  initial begin
    int n, py, px, seen;
    model_reset();
    #12;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;

    // basic stepping upward every TD cycles
    direction = 2'd0;
    run = 1'b1;
    cyc();
    for (int i = 1; i <= 12; i++) begin
      cyc();
      check_eq("t1_step", step, (i % TD == 0) ? 1 : 0);
    end
    check_eq("t1_y", head_y, 12);
    check_eq("t1_x", head_x, 20);

    // reach (39,5) heading right, then wrap in x
    for (int k = 0; k < 40 && my != 5; k++) wait_step("to_y5", n);
    direction = 2'd1;
    for (int k = 0; k < 40 && mx != 39; k++) wait_step("to_x39", n);
    wait_step("wrap_x", n);
    check_eq("wrap_x", head_x, 0);
    check_eq("wrap_x_y", head_y, 5);

    // reach (3,0) heading top, then wrap in y
    for (int k = 0; k < 40 && mx != 3; k++) wait_step("to_x3", n);
    direction = 2'd0;
    for (int k = 0; k < 40 && my != 0; k++) wait_step("to_y0", n);
    wait_step("wrap_y", n);
    check_eq("wrap_y", head_y, 29);
    check_eq("wrap_y_x", head_x, 3);

    // reversal rejected, then a legal turn
    py = my;
    direction = 2'd2;
    wait_step("rev", n);
    check_eq("rev_heading", heading, 0);
    check_eq("rev_y", head_y, (py + GH - 1) % GH);
    px = mx;
    direction = 2'd3;
    wait_step("turn", n);
    check_eq("turn_heading", heading, 3);
    check_eq("turn_x", head_x, (px + GW - 1) % GW);

    // pause mid-interval
    wait_cnt(2);
    run = 1'b0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      seen += step;
    end
    check_eq("pause_steps", seen, 0);
    check_eq("pause_state", state, 2);
    run = 1'b1;
    wait_step("resume", n);
    check_eq("resume_gap", n, 2);

    // restart on the tick cycle
    wait_cnt(TD - 1);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    check_eq("rs_step", step, 0);
    check_eq("rs_x", head_x, SX);
    check_eq("rs_y", head_y, SY);
    check_eq("rs_heading", heading, 0);
    check_eq("rs_state", state, 0);

    // asynchronous reset between edges
    direction = 2'd1;
    wait_step("pre_rst", n);
    wait_step("pre_rst2", n);
    @(posedge clk);
    model_clk();
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check_eq("arst_x", head_x, SX);
    check_eq("arst_state", state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    wait_step("arst_first", n);
    check_eq("arst_first_gap", n, TD);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      direction = 2'($urandom_range(0, 3));
      run = ($urandom_range(0, 9) != 0);
      restart = ($urandom_range(0, 59) == 0);
      cyc();
    end
    restart = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snake_head_stepper.md
# snake_head_stepper

Downstream consumer of the joystick direction stage: samples the requested 2-bit direction once per movement tick and advances the snake head one cell on a toroidal grid. It owns the game-speed timer, the committed heading with reversal rejection, and the head coordinates. Body and collision logic, plus the VGA renderer, read its outputs.

## Interface
Parameters:
- GRID_W, 40: grid width in cells.
- GRID_H, 30: grid height in cells.
- TICK_DIV, 2_500_000: clk cycles per movement step; at least 2.
- START_X, 20: head X after reset or restart.
- START_Y, 15: head Y after reset or restart.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- direction  in  [0:1]  requested heading from the joystick stage; TOP/RIGHT/DOWN/LEFT encoding.
- run  in  1  level: 1 = game advancing, 0 = paused.
- restart  in  1  one-cycle pulse: recentre the head and return to IDLE.
- head_x  out  XW = $clog2(GRID_W)  head column.
- head_y  out  YW = $clog2(GRID_H)  head row.
- heading  out  [0:1]  committed heading used by the last step.
- step  out  1  one-cycle pulse in the cycle head_x/head_y take their new value.
- state  out  [1:0]  IDLE = 0, RUN = 1, PAUSE = 2.

## Operation
- Reset values: head_x = START_X, head_y = START_Y, heading = TOP_DIR, step = 0, state = IDLE, tick counter = 0.
- FSM transitions:
  - IDLE to RUN when run = 1.
  - RUN to PAUSE when run = 0.
  - PAUSE to RUN when run = 1.
  - Any state to IDLE on restart. restart has priority over run and over a tick.
- Tick counter:
  - Increments only in RUN.
  - Holds its value in PAUSE.
  - Is cleared in IDLE and on restart.
  - At TICK_DIV-1 it wraps to 0 and a step fires.
- Step actions, in one cycle:
  - Latch the new heading: heading takes direction unless direction is the opposite of heading. An opposite request is ignored and heading is kept.
  - Move the head using the newly latched heading: TOP: y-1, DOWN: y+1, LEFT: x-1, RIGHT: x+1.
  - Wrap-around: x = GRID_W-1 moving RIGHT becomes 0, and x = 0 moving LEFT becomes GRID_W-1. Same rule for y with GRID_H.
  - Arithmetic is compare-and-select. No modulo operator and no overflow past the grid bound.
- direction is sampled only on the step cycle. Changes between steps are ignored; the last value present at the tick wins.
- If run falls on the tick cycle, the step still completes and the state becomes PAUSE.

## Timing
- First step fires TICK_DIV cycles after the IDLE to RUN transition.
- Later steps are spaced exactly TICK_DIV RUN-cycles apart. Paused cycles do not count.
- step, head_x, head_y and heading are registered and all update on the same clock edge. Zero combinational paths from inputs to outputs.
- restart: on the next edge, the outputs equal their reset values and step = 0. A tick that coincides with restart is discarded.
- rst_n asserted mid-step: all state returns to reset values asynchronously. Counting resumes only after deassertion and run = 1.
- The upstream direction stage shares clk, so no synchroniser is required.

## Structure
- Shared definitions in define.vh:
  - TOP_DIR = 2'b00, RIGHT_DIR = 2'b01, DOWN_DIR = 2'b10, LEFT_DIR = 2'b11.
  - Opposite directions therefore differ by XOR 2'b10; define.vh provides this as an OPPOSITE macro.
  - FSM state codes.
- One natural sub-module: tick_divider (parameter TICK_DIV; inputs en and clr; output a one-cycle tick). It is reused later for the food-blink timer.
- Coordinate next-state logic stays inline.

## Test plan
- Reset, then run = 1 with TICK_DIV = 4 and direction = TOP: step pulses at cycles 4, 8 and 12 after RUN entry. head_y goes 15, 14, 13, 12 and head_x stays 20.
- Head at (39, 5) with heading RIGHT, one tick: head becomes (0, 5). Head at (3, 0) with heading TOP: head becomes (3, 29).
- heading = TOP and direction = DOWN at the tick: heading stays TOP and head_y decrements. Next tick with direction = LEFT: heading becomes LEFT and head_x decrements.
- run dropped for 10 cycles mid-interval (counter at 2 of 4): state = PAUSE and no step pulses. After run returns, step fires 2 cycles later.
- restart pulsed on the same cycle as a tick: no step pulse, head = (20, 15), heading = TOP, state = IDLE.
- rst_n pulsed low asynchronously between clock edges during RUN: outputs immediately take their reset values. After release with run = 1, the first step occurs after TICK_DIV cycles.
